// File: rtl/match_controller_pkg.sv
`default_nettype none
// ============================================================================
// game_param : shared match state encoding and default game constants
// Revision   : 1.0
// ============================================================================
package game_param;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_ROUND_END = 3'd4,
        S_WIN       = 3'd5,
        S_LOSE      = 3'd6
    } match_state_t;

    localparam int DEF_HP_MAX        = 3;
    localparam int DEF_ROUNDS_TO_WIN = 2;

endpackage
`default_nettype wire

// File: rtl/match_controller_fighter_health.sv
`default_nettype none
// ============================================================================
// fighter_health : HP register, post-hit invincibility counter, hit acceptance
// Revision       : 1.0
// ============================================================================
module fighter_health
    import game_param::*;
#(
    parameter  int HP_MAX     = DEF_HP_MAX,
    parameter  int IFRAME_CYC = 32,
    localparam int HP_W       = $clog2(HP_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reload,
    input  logic            run,
    input  logic            freeze,
    input  logic            hit,
    input  logic            shield,
    output logic [HP_W-1:0] hp,
    output logic            iframe
);

    localparam int IF_W = $clog2(IFRAME_CYC + 1);

    logic [IF_W-1:0] iframe_cnt;
    logic            accept;

    // Hits landing during invincibility or behind a shield are simply dropped.
    assign accept = run && hit && !shield && (iframe_cnt == '0) && (hp != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp         <= HP_W'(HP_MAX);
            iframe_cnt <= '0;
            iframe     <= 1'b0;
        end else if (reload) begin
            hp         <= HP_W'(HP_MAX);
            iframe_cnt <= '0;
            iframe     <= 1'b0;
        end else if (accept) begin
            hp         <= hp - HP_W'(1);
            iframe_cnt <= IF_W'(IFRAME_CYC);
            iframe     <= 1'b1;
        end else if (run) begin
            if (iframe_cnt != '0) begin
                iframe_cnt <= iframe_cnt - IF_W'(1);
                iframe     <= (iframe_cnt != IF_W'(1));
            end
        end else if (!freeze) begin
            iframe_cnt <= '0;
            iframe     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
// match_controller : best-of-N duel sequencer (countdown, play, pause, rounds)
// Revision         : 1.0
// ============================================================================
module match_controller
    import game_param::*;
#(
    parameter  int ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
    parameter  int HP_MAX        = DEF_HP_MAX,
    parameter  int IFRAME_CYC    = 32,
    parameter  int COUNTDOWN_CYC = 64,
    parameter  int ROUND_END_CYC = 64,
    parameter  int AI_PERIOD     = 128,
    localparam int HP_W          = $clog2(HP_MAX + 1),
    localparam int RND_W         = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_select,
    input  logic             i_pause,
    input  logic             i_player_hit,
    input  logic             i_player_shield,
    input  logic             i_enemy_hit,
    input  logic             i_enemy_shield,
    output logic [2:0]       o_state,
    output logic             o_is_gaming,
    output logic [HP_W-1:0]  o_player_hp,
    output logic [HP_W-1:0]  o_enemy_hp,
    output logic             o_player_iframe,
    output logic             o_enemy_iframe,
    output logic [RND_W-1:0] o_player_rounds,
    output logic [RND_W-1:0] o_enemy_rounds,
    output logic             o_round_reset,
    output logic             o_ai_tick
);

    localparam int TMR_MAX = (COUNTDOWN_CYC > ROUND_END_CYC) ? COUNTDOWN_CYC : ROUND_END_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int AI_W    = $clog2(AI_PERIOD);

    localparam logic [TMR_W-1:0] CD_LAST = TMR_W'(COUNTDOWN_CYC - 1);
    localparam logic [TMR_W-1:0] RE_LAST = TMR_W'(ROUND_END_CYC - 1);
    localparam logic [AI_W-1:0]  AI_LAST = AI_W'(AI_PERIOD - 1);
    localparam logic [RND_W-1:0] RND_WIN = RND_W'(ROUNDS_TO_WIN);

    match_state_t     state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic [AI_W-1:0]  ai_cnt, ai_next;
    logic [RND_W-1:0] player_rounds, enemy_rounds;
    logic             round_reset, ai_tick, is_gaming;
    logic [HP_W-1:0]  player_hp, enemy_hp;
    logic             player_iframe, enemy_iframe;
    logic             ko, enter_cd, in_play, paused;

    assign ko       = (player_hp == '0) || (enemy_hp == '0);
    assign in_play  = (state == S_PLAY);
    assign paused   = (state == S_PAUSE);
    assign enter_cd = (state_next == S_COUNTDOWN) && (state != S_COUNTDOWN);

    always_comb begin
        state_next = state;
        timer_next = '0;
        ai_next    = '0;
        case (state)
            S_IDLE: if (i_select) state_next = S_COUNTDOWN;
            S_COUNTDOWN: begin
                if (timer == CD_LAST) state_next = S_PLAY;
                else                  timer_next = timer + TMR_W'(1);
            end
            S_PLAY: begin
                // A knockout takes priority over a pause request in the same cycle.
                if (ko) begin
                    state_next = S_ROUND_END;
                end else begin
                    ai_next = (ai_cnt == AI_LAST) ? '0 : ai_cnt + AI_W'(1);
                    if (i_pause) state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                ai_next = ai_cnt;
                if (i_pause) state_next = S_PLAY;
            end
            S_ROUND_END: begin
                if (timer == RE_LAST) begin
                    if (player_rounds == RND_WIN)     state_next = S_WIN;
                    else if (enemy_rounds == RND_WIN) state_next = S_LOSE;
                    else                              state_next = S_COUNTDOWN;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            S_WIN, S_LOSE: if (i_select) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            ai_cnt        <= '0;
            player_rounds <= '0;
            enemy_rounds  <= '0;
            round_reset   <= 1'b0;
            ai_tick       <= 1'b0;
            is_gaming     <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            ai_cnt      <= ai_next;
            round_reset <= enter_cd;
            is_gaming   <= (state_next == S_PLAY);
            ai_tick     <= (state_next == S_PLAY) && (ai_next == AI_LAST);
            // Simultaneous KO is a draw: neither counter moves.
            if (in_play && ko) begin
                if (enemy_hp == '0 && player_hp != '0 && player_rounds != RND_WIN)
                    player_rounds <= player_rounds + RND_W'(1);
                if (player_hp == '0 && enemy_hp != '0 && enemy_rounds != RND_WIN)
                    enemy_rounds <= enemy_rounds + RND_W'(1);
            end else if (state_next == S_IDLE && state != S_IDLE) begin
                player_rounds <= '0;
                enemy_rounds  <= '0;
            end
        end
    end

    fighter_health #(.HP_MAX(HP_MAX), .IFRAME_CYC(IFRAME_CYC)) u_player (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (enter_cd),
        .run    (in_play),
        .freeze (paused),
        .hit    (i_player_hit),
        .shield (i_player_shield),
        .hp     (player_hp),
        .iframe (player_iframe)
    );

    fighter_health #(.HP_MAX(HP_MAX), .IFRAME_CYC(IFRAME_CYC)) u_enemy (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (enter_cd),
        .run    (in_play),
        .freeze (paused),
        .hit    (i_enemy_hit),
        .shield (i_enemy_shield),
        .hp     (enemy_hp),
        .iframe (enemy_iframe)
    );

    assign o_state         = state;
    assign o_is_gaming     = is_gaming;
    assign o_player_hp     = player_hp;
    assign o_enemy_hp      = enemy_hp;
    assign o_player_iframe = player_iframe;
    assign o_enemy_iframe  = enemy_iframe;
    assign o_player_rounds = player_rounds;
    assign o_enemy_rounds  = enemy_rounds;
    assign o_round_reset   = round_reset;
    assign o_ai_tick       = ai_tick;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
// tb_match_controller : scoreboard bench for the duel match sequencer
// Revision            : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_match_controller;
    import game_param::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_select = 1'b0, i_pause = 1'b0;
    logic       i_player_hit = 1'b0, i_player_shield = 1'b0;
    logic       i_enemy_hit = 1'b0, i_enemy_shield = 1'b0;
    logic [2:0] o_state;
    logic       o_is_gaming, o_player_iframe, o_enemy_iframe, o_round_reset, o_ai_tick;
    logic [1:0] o_player_hp, o_enemy_hp, o_player_rounds, o_enemy_rounds;

    always #5 clk = ~clk;

    match_controller #(
        .ROUNDS_TO_WIN(2), .HP_MAX(3), .IFRAME_CYC(4),
        .COUNTDOWN_CYC(8), .ROUND_END_CYC(8), .AI_PERIOD(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_select(i_select), .i_pause(i_pause),
        .i_player_hit(i_player_hit), .i_player_shield(i_player_shield),
        .i_enemy_hit(i_enemy_hit), .i_enemy_shield(i_enemy_shield),
        .o_state(o_state), .o_is_gaming(o_is_gaming),
        .o_player_hp(o_player_hp), .o_enemy_hp(o_enemy_hp),
        .o_player_iframe(o_player_iframe), .o_enemy_iframe(o_enemy_iframe),
        .o_player_rounds(o_player_rounds), .o_enemy_rounds(o_enemy_rounds),
        .o_round_reset(o_round_reset), .o_ai_tick(o_ai_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int st; int php; int ehp; int pif; int eif; int tk; int rr;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk(int st, int php, int ehp, int pif, int eif, int tk, int rr);
        exp_t e;
        e.st = st; e.php = php; e.ehp = ehp; e.pif = pif; e.eif = eif; e.tk = tk; e.rr = rr;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (o_state !== S_IDLE) begin n_bad++; $display("FAIL rst_state got %0d want %0d", o_state, S_IDLE); end
        n_cmp++; if (o_player_hp !== 2'd3 || o_enemy_hp !== 2'd3) begin n_bad++; $display("FAIL rst_hp got %0d/%0d want 3/3", o_player_hp, o_enemy_hp); end
        n_cmp++; if (o_player_rounds !== 2'd0 || o_enemy_rounds !== 2'd0) begin n_bad++; $display("FAIL rst_rounds got %0d/%0d want 0/0", o_player_rounds, o_enemy_rounds); end
        n_cmp++; if ({o_is_gaming, o_player_iframe, o_enemy_iframe, o_round_reset, o_ai_tick} !== 5'b0) begin
            n_bad++; $display("FAIL rst_flags got %b want 00000", {o_is_gaming, o_player_iframe, o_enemy_iframe, o_round_reset, o_ai_tick});
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_cmp++; if (o_state !== S_IDLE) begin n_bad++; $display("FAIL rst_release_state got %0d want %0d", o_state, S_IDLE); end
    endtask

    task automatic test_countdown();
        exp_t e;
        for (int k = 0; k < 41; k++) begin
            i_select = (k == 0);
            if (k < 8) sb.push_back(mk(S_COUNTDOWN, 3, 3, 0, 0, 0, (k == 0) ? 1 : 0));
            else       sb.push_back(mk(S_PLAY, 3, 3, 0, 0, (k - 8 == 15 || k - 8 == 31) ? 1 : 0, 0));
            tick();
            e = sb.pop_front();
            n_cmp++; if (o_state !== 3'(e.st)) begin n_bad++; $display("FAIL cd_state k=%0d got %0d want %0d", k, o_state, e.st); end
            n_cmp++; if (o_round_reset !== 1'(e.rr)) begin n_bad++; $display("FAIL cd_round_reset k=%0d got %0d want %0d", k, o_round_reset, e.rr); end
            n_cmp++; if (o_ai_tick !== 1'(e.tk)) begin n_bad++; $display("FAIL cd_ai_tick k=%0d got %0d want %0d", k, o_ai_tick, e.tk); end
            n_cmp++; if (o_is_gaming !== ((e.st == S_PLAY) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL cd_is_gaming k=%0d got %0d", k, o_is_gaming); end
            n_cmp++; if (o_player_hp !== 2'(e.php) || o_enemy_hp !== 2'(e.ehp)) begin n_bad++; $display("FAIL cd_hp k=%0d got %0d/%0d want %0d/%0d", k, o_player_hp, o_enemy_hp, e.php, e.ehp); end
        end
        i_select = 1'b0;
    endtask

    task automatic test_enemy_hits();
        exp_t e;
        for (int k = 1; k <= 10; k++) begin
            i_enemy_hit = 1'b1;
            sb.push_back(mk(S_PLAY, 3, (k <= 5) ? 2 : 1, 0, (k == 5 || k == 10) ? 0 : 1, 0, 0));
            tick();
            e = sb.pop_front();
            n_cmp++; if (o_enemy_hp !== 2'(e.ehp)) begin n_bad++; $display("FAIL hit_enemy_hp k=%0d got %0d want %0d", k, o_enemy_hp, e.ehp); end
            n_cmp++; if (o_enemy_iframe !== 1'(e.eif)) begin n_bad++; $display("FAIL hit_enemy_iframe k=%0d got %0d want %0d", k, o_enemy_iframe, e.eif); end
            n_cmp++; if (o_player_hp !== 2'(e.php) || o_state !== 3'(e.st) || o_ai_tick !== 1'(e.tk)) begin
                n_bad++; $display("FAIL hit_misc k=%0d got php=%0d st=%0d tick=%0d", k, o_player_hp, o_state, o_ai_tick);
            end
        end
        i_enemy_hit = 1'b0;
    endtask

    task automatic test_shield();
        for (int k = 0; k < 6; k++) begin
            i_enemy_hit = 1'b1;
            i_enemy_shield = 1'b1;
            tick();
            n_cmp++; if (o_enemy_hp !== 2'd1 || o_enemy_iframe !== 1'b0) begin
                n_bad++; $display("FAIL shield_block k=%0d got hp=%0d iframe=%0d want 1/0", k, o_enemy_hp, o_enemy_iframe);
            end
            n_cmp++; if (o_state !== S_PLAY) begin n_bad++; $display("FAIL shield_state k=%0d got %0d want %0d", k, o_state, S_PLAY); end
        end
        i_enemy_hit = 1'b0;
        i_enemy_shield = 1'b0;
    endtask

    task automatic test_pause();
        exp_t e;
        for (int k = 0; k < 38; k++) begin
            i_player_hit = (k == 2) || (k >= 5 && k < 25);
            i_enemy_hit  = (k >= 5 && k < 25);
            i_select     = (k >= 5 && k < 25);
            i_pause      = (k == 4) || (k == 25);
            sb.push_back(mk((k >= 4 && k <= 24) ? S_PAUSE : S_PLAY, (k >= 2) ? 2 : 3, 1,
                            (k >= 2 && k <= 26) ? 1 : 0, 0, (k == 35) ? 1 : 0, 0));
            tick();
            e = sb.pop_front();
            n_cmp++; if (o_state !== 3'(e.st)) begin n_bad++; $display("FAIL pause_state k=%0d got %0d want %0d", k, o_state, e.st); end
            n_cmp++; if (o_player_hp !== 2'(e.php) || o_enemy_hp !== 2'(e.ehp)) begin n_bad++; $display("FAIL pause_hp k=%0d got %0d/%0d want %0d/%0d", k, o_player_hp, o_enemy_hp, e.php, e.ehp); end
            n_cmp++; if (o_player_iframe !== 1'(e.pif) || o_enemy_iframe !== 1'(e.eif)) begin n_bad++; $display("FAIL pause_iframe k=%0d got %0d/%0d want %0d/%0d", k, o_player_iframe, o_enemy_iframe, e.pif, e.eif); end
            n_cmp++; if (o_ai_tick !== 1'(e.tk)) begin n_bad++; $display("FAIL pause_ai_tick k=%0d got %0d want %0d", k, o_ai_tick, e.tk); end
        end
        {i_player_hit, i_enemy_hit, i_select, i_pause} = 4'b0;
    endtask

    task automatic test_draw();
        exp_t e;
        for (int k = 0; k < 15; k++) begin
            i_player_hit = (k == 0) || (k == 5);
            i_enemy_hit  = (k == 5);
            i_pause      = (k == 6);
            sb.push_back(mk((k <= 5) ? S_PLAY : ((k <= 13) ? S_ROUND_END : S_COUNTDOWN),
                            (k <= 4) ? 1 : ((k <= 13) ? 0 : 3),
                            (k <= 4) ? 1 : ((k <= 13) ? 0 : 3),
                            (k <= 3 || k == 5 || k == 6) ? 1 : 0,
                            (k == 5 || k == 6) ? 1 : 0, 0, (k == 14) ? 1 : 0));
            tick();
            e = sb.pop_front();
            n_cmp++; if (o_state !== 3'(e.st)) begin n_bad++; $display("FAIL draw_state k=%0d got %0d want %0d", k, o_state, e.st); end
            n_cmp++; if (o_player_hp !== 2'(e.php) || o_enemy_hp !== 2'(e.ehp)) begin n_bad++; $display("FAIL draw_hp k=%0d got %0d/%0d want %0d/%0d", k, o_player_hp, o_enemy_hp, e.php, e.ehp); end
            n_cmp++; if (o_player_iframe !== 1'(e.pif) || o_enemy_iframe !== 1'(e.eif)) begin n_bad++; $display("FAIL draw_iframe k=%0d got %0d/%0d want %0d/%0d", k, o_player_iframe, o_enemy_iframe, e.pif, e.eif); end
            n_cmp++; if (o_round_reset !== 1'(e.rr) || o_ai_tick !== 1'(e.tk)) begin n_bad++; $display("FAIL draw_pulses k=%0d got rr=%0d tick=%0d want %0d/%0d", k, o_round_reset, o_ai_tick, e.rr, e.tk); end
            n_cmp++; if (o_player_rounds !== 2'd0 || o_enemy_rounds !== 2'd0) begin n_bad++; $display("FAIL draw_rounds k=%0d got %0d/%0d want 0/0", k, o_player_rounds, o_enemy_rounds); end
        end
        {i_player_hit, i_enemy_hit, i_pause} = 3'b0;
    endtask

    task automatic test_match_win();
        int waited;
        for (int r = 1; r <= 2; r++) begin
            waited = 0;
            while (o_state !== S_PLAY && waited < 20) begin tick(); waited++; end
            n_cmp++; if (o_state !== S_PLAY || o_enemy_hp !== 2'd3) begin n_bad++; $display("FAIL win_reach_play r=%0d got st=%0d ehp=%0d want %0d/3", r, o_state, o_enemy_hp, S_PLAY); end
            i_select = 1'b1;
            tick();
            i_select = 1'b0;
            n_cmp++; if (o_state !== S_PLAY) begin n_bad++; $display("FAIL win_select_ignored r=%0d got %0d want %0d", r, o_state, S_PLAY); end
            i_enemy_hit = 1'b1;
            waited = 0;
            while (o_enemy_hp !== 2'd0 && waited < 30) begin tick(); waited++; end
            i_enemy_hit = 1'b0;
            n_cmp++; if (o_enemy_hp !== 2'd0) begin n_bad++; $display("FAIL win_ko r=%0d got ehp=%0d want 0", r, o_enemy_hp); end
            tick();
            n_cmp++; if (o_state !== S_ROUND_END) begin n_bad++; $display("FAIL win_round_end r=%0d got %0d want %0d", r, o_state, S_ROUND_END); end
            n_cmp++; if (o_player_rounds !== 2'(r) || o_enemy_rounds !== 2'd0) begin n_bad++; $display("FAIL win_rounds r=%0d got %0d/%0d want %0d/0", r, o_player_rounds, o_enemy_rounds, r); end
        end
        waited = 0;
        while (o_state === S_ROUND_END && waited < 20) begin tick(); waited++; end
        n_cmp++; if (o_state !== S_WIN || o_player_rounds !== 2'd2) begin n_bad++; $display("FAIL win_state got st=%0d rounds=%0d want %0d/2", o_state, o_player_rounds, S_WIN); end
        i_select = 1'b1;
        tick();
        i_select = 1'b0;
        n_cmp++; if (o_state !== S_IDLE) begin n_bad++; $display("FAIL win_to_idle got %0d want %0d", o_state, S_IDLE); end
        n_cmp++; if (o_player_rounds !== 2'd0 || o_enemy_rounds !== 2'd0) begin n_bad++; $display("FAIL win_rounds_clear got %0d/%0d want 0/0", o_player_rounds, o_enemy_rounds); end
    endtask

    task automatic test_async_reset();
        int waited;
        i_select = 1'b1;
        tick();
        i_select = 1'b0;
        waited = 0;
        while (o_state !== S_PLAY && waited < 12) begin tick(); waited++; end
        i_enemy_hit = 1'b1;
        tick();
        i_enemy_hit = 1'b0;
        n_cmp++; if (o_enemy_hp !== 2'd2 || o_state !== S_PLAY) begin n_bad++; $display("FAIL arst_setup got ehp=%0d st=%0d want 2/%0d", o_enemy_hp, o_state, S_PLAY); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_state !== S_IDLE || o_is_gaming !== 1'b0) begin n_bad++; $display("FAIL arst_state got %0d/%0d want %0d/0", o_state, o_is_gaming, S_IDLE); end
        n_cmp++; if (o_enemy_hp !== 2'd3 || o_enemy_iframe !== 1'b0) begin n_bad++; $display("FAIL arst_enemy got hp=%0d iframe=%0d want 3/0", o_enemy_hp, o_enemy_iframe); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_cmp++; if (o_state !== S_IDLE) begin n_bad++; $display("FAIL arst_release got %0d want %0d", o_state, S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_enemy_hits();
        test_shield();
        test_pause();
        test_draw();
        test_match_win();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
